// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: opcodes, ALU operations and sequencer states.
package cpu_pkg;

   localparam int unsigned INSTR_W  = 8;
   localparam int unsigned IMM_W    = 4;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned ALU_OP_W = 3;

   // Opcode field values (instruction [7:4]); 9..E are undefined.
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_AND = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_OR  = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_XOR = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   // ALU operation codes shared with the ALU.
   localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 3'd0;
   localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'd1;
   localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'd2;
   localparam logic [ALU_OP_W-1:0] ALU_AND    = 3'd3;
   localparam logic [ALU_OP_W-1:0] ALU_OR     = 3'd4;
   localparam logic [ALU_OP_W-1:0] ALU_XOR    = 3'd5;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: opcode classification and ALU control.
module seq_decode
   import cpu_pkg::*;
#(
   parameter int unsigned OPC_W = 4
) (
   input  logic [OPC_W-1:0]    opcode,
   input  logic                zero_q,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                use_imm,
   output logic                is_alu,
   output logic                is_jmp,
   output logic                is_jz,
   output logic                is_hlt,
   output logic                is_illegal,
   output logic                jz_taken
);

   // Classify the opcode; anything not listed is undefined and behaves as a NOP.
   always_comb begin
      alu_op     = ALU_PASS_B;
      use_imm    = 1'b0;
      is_alu     = 1'b0;
      is_jmp     = 1'b0;
      is_jz      = 1'b0;
      is_hlt     = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OPC_W'(OP_LDI): begin
            use_imm = 1'b1;
            is_alu  = 1'b1;
         end
         OPC_W'(OP_ADD): begin
            alu_op = ALU_ADD;
            is_alu = 1'b1;
         end
         OPC_W'(OP_SUB): begin
            alu_op = ALU_SUB;
            is_alu = 1'b1;
         end
         OPC_W'(OP_AND): begin
            alu_op = ALU_AND;
            is_alu = 1'b1;
         end
         OPC_W'(OP_OR): begin
            alu_op = ALU_OR;
            is_alu = 1'b1;
         end
         OPC_W'(OP_XOR): begin
            alu_op = ALU_XOR;
            is_alu = 1'b1;
         end
         OPC_W'(OP_JMP): is_jmp = 1'b1;
         OPC_W'(OP_JZ):  is_jz  = 1'b1;
         OPC_W'(OP_NOP): ;
         OPC_W'(OP_HLT): is_hlt = 1'b1;
         default:        is_illegal = 1'b1;
      endcase
   end

   // JZ branches on the flag left by the most recent LDI/ALU instruction.
   assign jz_taken = is_jz & zero_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC control sequencer with run/step/resume debug control.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned RETIRE_W = 8,
   parameter int unsigned OPC_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [INSTR_W-1:0]  instr_in,
   input  logic                alu_zero,
   input  logic                run,
   input  logic                step,
   input  logic                resume,
   output logic [INSTR_W-1:0]  ir_out,
   output logic [IMM_W-1:0]    immediate,
   output logic                use_imm,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_write_enable,
   output logic                pc_enable,
   output logic                pc_load,
   output logic                zero_q,
   output logic                halt,
   output logic                busy,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   state_e               state_q, state_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic                 zero_d;
   logic                 illegal_q, illegal_d;
   logic [RETIRE_W-1:0]  retired_q, retired_d;

   logic [OPC_W-1:0]     opcode;
   logic                 is_alu, is_jmp, is_jz, is_hlt, is_illegal, jz_taken;

   assign opcode    = ir_q[INSTR_W-1 -: OPC_W];
   assign ir_out    = ir_q;
   assign immediate = ir_q[IMM_W-1:0];
   assign illegal   = illegal_q;
   assign retired   = retired_q;

   // Opcode decode from the latched instruction, valid in every state.
   seq_decode #(
      .OPC_W (OPC_W)
   ) u_decode (
      .opcode     (opcode),
      .zero_q     (zero_q),
      .alu_op     (alu_op),
      .use_imm    (use_imm),
      .is_alu     (is_alu),
      .is_jmp     (is_jmp),
      .is_jz      (is_jz),
      .is_hlt     (is_hlt),
      .is_illegal (is_illegal),
      .jz_taken   (jz_taken)
   );

   // State, IR, zero flag, sticky illegal and retire counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ir_q      <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and strobe logic; strobes decode from the state so reset kills them at once.
   always_comb begin
      state_d          = state_q;
      ir_d             = ir_q;
      zero_d           = zero_q;
      illegal_d        = illegal_q;
      retired_d        = retired_q;
      reg_write_enable = 1'b0;
      pc_enable        = 1'b0;
      pc_load          = 1'b0;
      halt             = 1'b0;
      busy             = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run || step) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            busy    = 1'b1;
            ir_d    = instr_in;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            // Settle cycle for memory and register file.
            busy    = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            busy = 1'b1;
            if (retired_q != {RETIRE_W{1'b1}}) retired_d = retired_q + RETIRE_W'(1);
            if (is_alu) begin
               reg_write_enable = 1'b1;
               zero_d           = alu_zero;
               pc_enable        = 1'b1;
            end else if (is_jmp) begin
               pc_load = 1'b1;
            end else if (is_jz) begin
               pc_load   = jz_taken;
               pc_enable = ~jz_taken;
            end else if (!is_hlt) begin
               pc_enable = 1'b1;
            end
            if (is_illegal) illegal_d = 1'b1;
            if (is_hlt)     state_d = ST_HALTED;
            else if (run)   state_d = ST_FETCH;
            else            state_d = ST_IDLE;
         end
         ST_HALTED: begin
            halt = 1'b1;
            if (resume) begin
               // Step the PC past the HLT on the way out.
               pc_enable = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  instr_in;
   logic        alu_zero;
   logic        run;
   logic        step;
   logic        resume;
   logic [7:0]  ir_out;
   logic [3:0]  immediate;
   logic        use_imm;
   logic [2:0]  alu_op;
   logic        reg_write_enable;
   logic        pc_enable;
   logic        pc_load;
   logic        zero_q;
   logic        halt;
   logic        busy;
   logic        illegal;
   logic [7:0]  retired;

   int total = 0;
   int bad   = 0;

   cpu_sequencer #(
      .RETIRE_W (8),
      .OPC_W    (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .instr_in         (instr_in),
      .alu_zero         (alu_zero),
      .run              (run),
      .step             (step),
      .resume           (resume),
      .ir_out           (ir_out),
      .immediate        (immediate),
      .use_imm          (use_imm),
      .alu_op           (alu_op),
      .reg_write_enable (reg_write_enable),
      .pc_enable        (pc_enable),
      .pc_load          (pc_load),
      .zero_q           (zero_q),
      .halt             (halt),
      .busy             (busy),
      .illegal          (illegal),
      .retired          (retired)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From IDLE with run=0: single-step one instruction and stop in its EXEC cycle.
   task automatic step_to_exec(input logic [7:0] ins, input logic az);
      instr_in = ins;
      step     = 1'b1;
      tick();
      step     = 1'b0;
      tick();
      alu_zero = az;
      tick();
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; step = 1'b0; resume = 1'b0;
      instr_in = 8'h00; alu_zero = 1'b0;
      #12;
      chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("rst_ir", 32'(ir_out), 32'h00);
      chk("rst_zero", 32'(zero_q), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_retired", 32'(retired), 32'h0);
      chk("rst_strobes", 32'({reg_write_enable, pc_enable, pc_load, halt, busy}), 32'h0);
      chk("rst_use_imm", 32'(use_imm), 32'h1);

      @(posedge clk); #1; rst = 1'b1;
      tick();
      chk("idle_hold", 32'(dut.state_q), 32'(ST_IDLE));

      // LDI 5 in run mode
      instr_in = 8'h05; run = 1'b1;
      tick();
      chk("ldi_fetch", 32'({busy, pc_enable, reg_write_enable}), 32'b100);
      tick();
      chk("ldi_ir", 32'(ir_out), 32'h05);
      chk("ldi_decode", 32'({dut.state_q, reg_write_enable, pc_enable, pc_load}), 32'({ST_DECODE, 3'b000}));
      run = 1'b0;
      tick();
      chk("ldi_exec", 32'({reg_write_enable, use_imm, alu_op, pc_enable, pc_load}), 32'b11_000_10);
      chk("ldi_ret_pre", 32'(retired), 32'd0);
      tick();
      chk("ldi_idle", 32'(dut.state_q), 32'(ST_IDLE));
      chk("ldi_ret", 32'(retired), 32'd1);

      // SUB giving zero, then JZ taken
      step_to_exec(8'h21, 1'b1);
      chk("sub_exec", 32'({alu_op, reg_write_enable, pc_enable, use_imm}), 32'b010_11_0);
      tick();
      chk("sub_zero", 32'(zero_q), 32'h1);
      step_to_exec(8'h7A, 1'b0);
      chk("jz_imm", 32'(immediate), 32'hA);
      chk("jz_taken", 32'({pc_load, pc_enable, reg_write_enable}), 32'b100);
      tick();
      chk("jz_keep_zero", 32'(zero_q), 32'h1);
      chk("jz_ret", 32'(retired), 32'd3);

      // SUB non-zero, then JZ not taken
      step_to_exec(8'h21, 1'b0);
      tick();
      chk("sub_nz", 32'(zero_q), 32'h0);
      step_to_exec(8'h7A, 1'b0);
      chk("jz_fall", 32'({pc_load, pc_enable}), 32'b01);
      tick();
      chk("jz2_ret", 32'(retired), 32'd5);

      // Step pulse during DECODE is ignored
      instr_in = 8'h80; step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("nop_exec", 32'({pc_enable, pc_load, reg_write_enable}), 32'b100);
      tick();
      chk("nop_idle1", 32'(dut.state_q), 32'(ST_IDLE));
      tick();
      chk("nop_idle2", 32'(dut.state_q), 32'(ST_IDLE));
      chk("nop_ret", 32'(retired), 32'd6);

      // HLT, ignored run/step, then resume
      step_to_exec(8'hF0, 1'b0);
      chk("hlt_exec", 32'({pc_enable, pc_load, reg_write_enable}), 32'b000);
      tick();
      chk("hlt_state", 32'({halt, busy}), 32'b10);
      chk("hlt_ret", 32'(retired), 32'd7);
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("hlt_run_ign", 32'({dut.state_q, halt}), 32'({ST_HALTED, 1'b1}));
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("hlt_step_ign", 32'(halt), 32'h1);
      chk("hlt_no_pc", 32'({pc_enable, pc_load}), 32'b00);
      resume = 1'b1;
      #1;
      chk("resume_pc", 32'({pc_enable, pc_load}), 32'b10);
      tick();
      resume = 1'b0;
      chk("resume_idle", 32'({dut.state_q, halt, pc_enable}), 32'({ST_IDLE, 2'b00}));

      // Undefined opcode 0xB3, then LDI keeps illegal set
      step_to_exec(8'hB3, 1'b0);
      chk("ill_exec", 32'({pc_enable, reg_write_enable, alu_op}), 32'b10_000);
      tick();
      chk("ill_set", 32'(illegal), 32'h1);
      chk("ill_ret", 32'(retired), 32'd8);
      step_to_exec(8'h07, 1'b1);
      chk("ldi2_exec", 32'(reg_write_enable), 32'h1);
      tick();
      chk("ill_sticky", 32'(illegal), 32'h1);
      chk("ldi2_zero", 32'(zero_q), 32'h1);

      // Free-run JMP then ADD, reset during ADD EXEC
      run = 1'b1; instr_in = 8'h63;
      tick(); tick(); tick();
      chk("jmp_exec", 32'({pc_load, pc_enable, reg_write_enable}), 32'b100);
      instr_in = 8'h12;
      tick();
      chk("jmp_to_fetch", 32'(dut.state_q), 32'(ST_FETCH));
      chk("jmp_ret", 32'(retired), 32'd10);
      chk("jmp_keep_zero", 32'(zero_q), 32'h1);
      tick(); tick();
      chk("add_exec", 32'({dut.state_q, reg_write_enable, alu_op}), 32'({ST_EXEC, 1'b1, ALU_ADD}));
      #2 rst = 1'b0;
      #1;
      chk("arst_strobes", 32'({reg_write_enable, pc_enable, pc_load, busy, halt}), 32'h0);
      chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("arst_regs", 32'({illegal, retired, ir_out, zero_q}), 32'h0);

      // Retire counter saturation over 300 NOPs
      instr_in = 8'h80;
      @(posedge clk); #1; rst = 1'b1;
      repeat (301) tick();
      chk("sat_mid", 32'(retired), 32'd100);
      repeat (600) tick();
      run = 1'b0;
      repeat (4) tick();
      chk("sat_end", 32'(retired), 32'd255);
      chk("sat_idle", 32'(dut.state_q), 32'(ST_IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
